// File: rtl/spi_periph_pkg.sv
// spi_periph_pkg: shared types and sizes for the SPI peripheral slice.
// Holds the requester id enum and the register-file geometry.
package spi_periph_pkg;

  localparam int REGFILE_ADDR_W = 4;
  localparam int REGFILE_DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_SPI  = 2'd1,
    REQ_DBG  = 2'd2,
    REQ_DISP = 2'd3
  } req_id_t;

endpackage

// File: rtl/spi_regfile_arbiter_if.sv
// spi_regfile_arbiter_if: requester ports (spi/dbg/disp), memory port, busy.
// slave = arbiter side, master = requesters plus register-file macro.
interface spi_regfile_arbiter_if
  import spi_periph_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int DATA_W = REGFILE_DATA_W
);

  logic              spi_req;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_gnt;
  logic              spi_rvalid;
  logic [DATA_W-1:0] spi_rdata;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  spi_req, spi_we, spi_addr, spi_wdata,
    input  dbg_req, dbg_addr,
    input  disp_req, disp_addr,
    input  mem_rdata,
    output spi_gnt, spi_rvalid, spi_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output disp_gnt, disp_rvalid, disp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output spi_req, spi_we, spi_addr, spi_wdata,
    output dbg_req, dbg_addr,
    output disp_req, disp_addr,
    output mem_rdata,
    input  spi_gnt, spi_rvalid, spi_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/spi_regfile_arb_pick.sv
// spi_regfile_arb_pick: combinational one-hot grant picker.
// req/gnt bits {disp,dbg,spi}; rr_ptr 0=dbg next; starve {disp,dbg}.
module spi_regfile_arb_pick (
  input  logic [2:0] req,
  input  logic       rr_ptr,
  input  logic [1:0] starve,
  output logic [2:0] gnt
);

  logic [1:0] hungry;

  // stale counter values may outlive a dropped req
  assign hungry = starve & req[2:1];

  function automatic logic [1:0] rr_pick(
    input logic [1:0] cand,
    input logic       ptr
  );
    if (&cand) return ptr ? 2'b10 : 2'b01;
    return cand;
  endfunction

  always_comb begin
    gnt = '0;
    if (|hungry)
      gnt = {rr_pick(hungry, rr_ptr), 1'b0};
    else if (req[0])
      gnt = 3'b001;
    else
      gnt = {rr_pick(req[2:1], rr_ptr), 1'b0};
  end

endmodule

// File: rtl/spi_regfile_arbiter.sv
// spi_regfile_arbiter: shares a 16x8 single-port regfile between spi,
// dbg and disp. Ports: clk, rst (sync, active-high), bus (slave modport).
// Optional SPI_ARB_STARVE_GUARD_EN: force-grant dbg/disp after STARVE_MAX.
module spi_regfile_arbiter
  import spi_periph_pkg::*;
#(
  parameter int ADDR_W     = REGFILE_ADDR_W,
  parameter int DATA_W     = REGFILE_DATA_W,
  parameter int STARVE_MAX = 7
) (
  input logic                  clk,
  input logic                  rst,
  spi_regfile_arbiter_if.slave bus
);

  logic [2:0]        req;
  logic [2:0]        gnt;
  logic [1:0]        starve;
  logic              rr_ptr;
  req_id_t           issue_tag;
  req_id_t           tag0;
  req_id_t           tag1;
  logic [DATA_W-1:0] spi_q;
  logic [DATA_W-1:0] dbg_q;
  logic [DATA_W-1:0] disp_q;

  assign req = {bus.disp_req, bus.dbg_req, bus.spi_req};

  spi_regfile_arb_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .starve (starve),
    .gnt    (gnt)
  );

  assign bus.spi_gnt  = gnt[0];
  assign bus.dbg_gnt  = gnt[1];
  assign bus.disp_gnt = gnt[2];
  assign bus.mem_en   = |gnt;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    issue_tag     = REQ_NONE;
    unique case (1'b1)
      gnt[0]: begin
        bus.mem_we    = bus.spi_we;
        bus.mem_addr  = bus.spi_addr;
        bus.mem_wdata = bus.spi_wdata;
        if (!bus.spi_we) issue_tag = REQ_SPI;
      end
      gnt[1]: begin
        bus.mem_addr = bus.dbg_addr;
        issue_tag    = REQ_DBG;
      end
      gnt[2]: begin
        bus.mem_addr = bus.disp_addr;
        issue_tag    = REQ_DISP;
      end
      default: ;
    endcase
  end

  // tag0: read issued last cycle, mem_rdata valid now
  // tag1: data captured last cycle, rvalid now
  always_ff @(posedge clk) begin
    if (rst) begin
      tag0   <= REQ_NONE;
      tag1   <= REQ_NONE;
      rr_ptr <= 1'b0;
      spi_q  <= '0;
      dbg_q  <= '0;
      disp_q <= '0;
    end else begin
      tag0 <= issue_tag;
      tag1 <= tag0;
      case (tag0)
        REQ_SPI:  spi_q  <= bus.mem_rdata;
        REQ_DBG:  dbg_q  <= bus.mem_rdata;
        REQ_DISP: disp_q <= bus.mem_rdata;
        default:  ;
      endcase
      if (gnt[1])
        rr_ptr <= 1'b1;
      else if (gnt[2])
        rr_ptr <= 1'b0;
    end
  end

  assign bus.spi_rvalid  = (tag1 == REQ_SPI);
  assign bus.dbg_rvalid  = (tag1 == REQ_DBG);
  assign bus.disp_rvalid = (tag1 == REQ_DISP);
  assign bus.spi_rdata   = spi_q;
  assign bus.dbg_rdata   = dbg_q;
  assign bus.disp_rdata  = disp_q;

  assign bus.busy = (|req)
                  | (tag0 != REQ_NONE)
                  | (tag1 != REQ_NONE);

`ifdef SPI_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] dbg_wait;
  logic [CNT_W-1:0] disp_wait;

  function automatic logic [CNT_W-1:0] wait_next(
    input logic             r,
    input logic             g,
    input logic [CNT_W-1:0] c
  );
    if (!r || g) return '0;
    if (c != CNT_MAX) return c + 1'b1;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_wait  <= '0;
      disp_wait <= '0;
    end else begin
      dbg_wait  <= wait_next(bus.dbg_req, gnt[1], dbg_wait);
      disp_wait <= wait_next(bus.disp_req, gnt[2], disp_wait);
    end
  end

  assign starve = {disp_wait == CNT_MAX, dbg_wait == CNT_MAX};
`else
  assign starve = 2'b00;
`endif

endmodule
